// File: rtl/sb_pkg.sv
// Shared fixed-point word type and saturating multiply/subtract helpers for the momentum pipe.
// Combinational helpers only; no latency, no flow control.
package sb_pkg;

   localparam int DW = 32;
   localparam int FW = 16;

   typedef logic signed [DW-1:0] word_t;

   localparam word_t SAT_MAX = {1'b0, {(DW-1){1'b1}}};
   localparam word_t SAT_MIN = {1'b1, {(DW-1){1'b0}}};

   typedef struct packed {
      word_t val;
      logic  sat;
   } sat_res_t;

   // Full-width product, floor shift back to Q format, then clamp.
   function automatic sat_res_t sat_mul(input word_t a, input word_t b);
      logic signed [2*DW-1:0] prod;
      sat_res_t               r;
      prod = (2*DW)'(a) * (2*DW)'(b);
      prod = prod >>> FW;
      if (prod > (2*DW)'(SAT_MAX)) begin
         r.val = SAT_MAX;
         r.sat = 1'b1;
      end else if (prod < (2*DW)'(SAT_MIN)) begin
         r.val = SAT_MIN;
         r.sat = 1'b1;
      end else begin
         r.val = prod[DW-1:0];
         r.sat = 1'b0;
      end
      return r;
   endfunction

   function automatic sat_res_t sat_sub(input word_t a, input word_t b);
      logic signed [DW:0] d;
      sat_res_t           r;
      d     = (DW+1)'(a) - (DW+1)'(b);
      r.sat = d[DW] ^ d[DW-1];
      if (r.sat) r.val = d[DW] ? SAT_MIN : SAT_MAX;
      else       r.val = d[DW-1:0];
      return r;
   endfunction

endpackage

// File: rtl/sb_momentum_pipe_if.sv
// Beat-level valid/ready bundle between the Jx unit, the momentum pipe and the position updater.
// Master drives beats in and accepts results; slave is the pipe itself.
interface sb_momentum_pipe_if #(
   parameter int N          = 8,
   parameter int LANES      = 4,
   parameter int DATA_WIDTH = 32
);
   localparam int BEATS = N / LANES;
   localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic                        in_valid;
   logic                        in_ready;
   logic [LANES*DATA_WIDTH-1:0] in_y;
   logic [LANES*DATA_WIDTH-1:0] in_x;
   logic [LANES*DATA_WIDTH-1:0] in_jx;
   logic [LANES*DATA_WIDTH-1:0] in_p;
   logic [DATA_WIDTH-1:0]       dt;
   logic [DATA_WIDTH-1:0]       c0;
   logic                        out_valid;
   logic                        out_ready;
   logic [LANES*DATA_WIDTH-1:0] out_y_next;
   logic [IDX_W-1:0]            out_idx;
   logic                        out_last;

   modport master (
      output in_valid, in_y, in_x, in_jx, in_p, dt, c0, out_ready,
      input  in_ready, out_valid, out_y_next, out_idx, out_last
   );

   modport slave (
      input  in_valid, in_y, in_x, in_jx, in_p, dt, c0, out_ready,
      output in_ready, out_valid, out_y_next, out_idx, out_last
   );

endinterface

// File: rtl/sb_momentum_lane.sv
// One lane of y_next = y - dt*(p*x - c0*Jx), saturating, with a sticky per-beat sat flag.
// Latency 4; every register advances only on en, so backpressure freezes the lane in place.
module sb_momentum_lane
   import sb_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  en,
   input  word_t y,
   input  word_t x,
   input  word_t jx,
   input  word_t p,
   input  word_t dt,
   input  word_t c0,
   output word_t y_next,
   output logic  sat
);

   word_t    px1, cj1, y1, dt1;
   logic     sat1;
   word_t    d2, y2, dt2;
   logic     sat2;
   word_t    t3, y3;
   logic     sat3;
   sat_res_t px_r, cj_r, d_r, t_r, yn_r;

   always_comb begin
      px_r = sat_mul(p, x);
      cj_r = sat_mul(c0, jx);
      d_r  = sat_sub(px1, cj1);
      t_r  = sat_mul(dt2, d2);
      yn_r = sat_sub(y3, t3);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         px1 <= '0; cj1 <= '0; y1 <= '0; dt1 <= '0; sat1 <= 1'b0;
         d2  <= '0; y2  <= '0; dt2 <= '0; sat2 <= 1'b0;
         t3  <= '0; y3  <= '0; sat3 <= 1'b0;
         y_next <= '0; sat <= 1'b0;
      end else if (en) begin
         px1    <= px_r.val;
         cj1    <= cj_r.val;
         y1     <= y;
         dt1    <= dt;
         sat1   <= px_r.sat | cj_r.sat;
         d2     <= d_r.val;
         y2     <= y1;
         dt2    <= dt1;
         sat2   <= sat1 | d_r.sat;
         t3     <= t_r.val;
         y3     <= y2;
         sat3   <= sat2 | t_r.sat;
         y_next <= yn_r.val;
         sat    <= sat3 | yn_r.sat;
      end
   end

endmodule

// File: rtl/sb_momentum_pipe.sv
// LANES-wide momentum updater with per-frame beat index and saturation-event counter.
// Latency 4; whole pipe freezes while out_valid && !out_ready, in_ready = that enable (and !flush).
module sb_momentum_pipe
   import sb_pkg::*;
#(
   parameter int N             = 8,
   parameter int LANES         = 4,
   parameter int DATA_WIDTH    = 32,
   parameter int FRAC_WIDTH    = 16,
   parameter int SAT_CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     clear_stats,
   output logic [SAT_CNT_WIDTH-1:0] sat_count,
   sb_momentum_pipe_if.slave        bus
);

   localparam int BEATS = N / LANES;
   localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   if (N % LANES != 0) begin : g_chk_frame
      $error("sb_momentum_pipe: N must be a multiple of LANES");
   end
   if (DATA_WIDTH != DW || FRAC_WIDTH != FW) begin : g_chk_fmt
      $error("sb_momentum_pipe: word format must match sb_pkg");
   end

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             last;
   } meta_t;

   logic             en;
   logic             acc;
   logic [3:0]       stg_vld;
   meta_t [3:0]      meta_q;
   meta_t            meta_in;
   logic [IDX_W-1:0] beat_cnt;
   logic [LANES-1:0] lane_sat;

   assign en           = !stg_vld[3] || bus.out_ready;
   assign bus.in_ready = en && !flush;
   assign acc          = bus.in_valid && bus.in_ready;

   assign meta_in.idx  = beat_cnt;
   assign meta_in.last = (beat_cnt == IDX_W'(BEATS - 1));

   assign bus.out_valid = stg_vld[3];
   assign bus.out_idx   = meta_q[3].idx;
   assign bus.out_last  = meta_q[3].last;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      sb_momentum_lane u_lane (
         .clk    (clk),
         .rst_n  (rst_n),
         .en     (en),
         .y      (bus.in_y [l*DATA_WIDTH +: DATA_WIDTH]),
         .x      (bus.in_x [l*DATA_WIDTH +: DATA_WIDTH]),
         .jx     (bus.in_jx[l*DATA_WIDTH +: DATA_WIDTH]),
         .p      (bus.in_p [l*DATA_WIDTH +: DATA_WIDTH]),
         .dt     (bus.dt),
         .c0     (bus.c0),
         .y_next (bus.out_y_next[l*DATA_WIDTH +: DATA_WIDTH]),
         .sat    (lane_sat[l])
      );
   end

   // Lane data may keep shifting under flush; only the valids decide what emerges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     stg_vld <= '0;
      else if (flush) stg_vld <= '0;
      else if (en)    stg_vld <= {stg_vld[2:0], acc};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  meta_q <= '0;
      else if (en) meta_q <= {meta_q[2:0], meta_in};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     beat_cnt <= '0;
      else if (flush) beat_cnt <= '0;
      else if (acc)   beat_cnt <= meta_in.last ? '0 : beat_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sat_count <= '0;
      else if (clear_stats)
         sat_count <= '0;
      else if (stg_vld[3] && bus.out_ready && (|lane_sat) && !(&sat_count))
         sat_count <= sat_count + SAT_CNT_WIDTH'(1);
   end

endmodule

// File: tb/tb_sb_momentum_pipe.sv
// Scoreboard bench for sb_momentum_pipe: directed per-lane vectors with hand-computed results.
// A monitor pops expected beats on each output handshake and tracks sat_count independently.
module tb_sb_momentum_pipe;

   localparam int N   = 8;
   localparam int LN  = 4;
   localparam int DW  = 32;
   localparam int SCW = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           flush = 1'b0;
   logic           clear_stats = 1'b0;
   logic [SCW-1:0] sat_count;

   sb_momentum_pipe_if #(.N(N), .LANES(LN), .DATA_WIDTH(DW)) bus ();

   sb_momentum_pipe #(
      .N(N), .LANES(LN), .DATA_WIDTH(DW), .FRAC_WIDTH(16), .SAT_CNT_WIDTH(SCW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .clear_stats(clear_stats),
      .sat_count(sat_count), .bus(bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] y, x, p, jx, c0, dt, exp;
      bit          sat;
   } vec_t;

   typedef struct {
      logic [127:0] y;
      int           idx;
      bit           last;
      bit           sat;
      int           cyc;
      bit           chk_lat;
   } exp_t;

   vec_t         vt [7];
   exp_t         sb_q [$];
   exp_t         mon_e;
   logic         mon_hs, mon_clr;
   logic [127:0] hold;
   int           n_cmp = 0;
   int           n_err = 0;
   int           tb_idx = 0;
   int           exp_sat = 0;
   int           pat [4][4] = '{'{1, 1, 1, 1}, '{2, 3, 5, 6}, '{0, 0, 0, 0}, '{6, 5, 3, 2}};

   task automatic chk_v(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_i(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input int l0, input int l1, input int l2, input int l3);
      bus.in_y  = {vt[l3].y,  vt[l2].y,  vt[l1].y,  vt[l0].y};
      bus.in_x  = {vt[l3].x,  vt[l2].x,  vt[l1].x,  vt[l0].x};
      bus.in_p  = {vt[l3].p,  vt[l2].p,  vt[l1].p,  vt[l0].p};
      bus.in_jx = {vt[l3].jx, vt[l2].jx, vt[l1].jx, vt[l0].jx};
      bus.dt    = vt[l0].dt;
      bus.c0    = vt[l0].c0;
   endtask

   // Present one beat, wait (bounded) for acceptance, queue its expected result.
   task automatic send(input int l0, input int l1, input int l2, input int l3, input bit lat);
      int   waited = 0;
      exp_t e;
      drive(l0, l1, l2, l3);
      bus.in_valid = 1'b1;
      while (1) begin
         @(negedge clk);
         if (bus.in_ready === 1'b1) break;
         waited++;
         if (waited > 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, want 1");
            bus.in_valid = 1'b0;
            return;
         end
      end
      e.y       = {vt[l3].exp, vt[l2].exp, vt[l1].exp, vt[l0].exp};
      e.idx     = tb_idx;
      e.last    = (tb_idx == 1);
      e.sat     = vt[l0].sat | vt[l1].sat | vt[l2].sat | vt[l3].sat;
      e.cyc     = cyc;
      e.chk_lat = lat;
      sb_q.push_back(e);
      tb_idx = (tb_idx + 1) % 2;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int w = 0;
      while (sb_q.size() > 0 && w < 100) begin
         step(1);
         w++;
      end
      chk_i("drain_pending", sb_q.size(), 0);
      step(2);
   endtask

   // Output monitor: compare on every handshake, model sat_count alongside.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            mon_hs  = bus.out_valid && bus.out_ready;
            mon_clr = clear_stats;
            if (mon_hs) begin
               if (sb_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_output: got beat 0x%0h, want none", bus.out_y_next);
               end else begin
                  mon_e = sb_q.pop_front();
                  chk_v("y_next", bus.out_y_next, mon_e.y);
                  chk_i("idx", int'(bus.out_idx), mon_e.idx);
                  chk_i("last", int'(bus.out_last), int'(mon_e.last));
                  if (mon_e.chk_lat) chk_i("latency", cyc - mon_e.cyc, 4);
                  if (mon_e.sat && exp_sat < 3) exp_sat++;
               end
            end
            if (mon_clr) exp_sat = 0;
            if (mon_hs || mon_clr) begin
               @(posedge clk);
               #1;
               chk_i("sat_count", int'(sat_count), exp_sat);
            end
         end
      end
   end

   initial begin
      //                y             x             p             jx            c0            dt            expected      sat
      vt[0] = '{32'h00010000, 32'h00020000, 32'h00008000, 32'h00004000, 32'h00010000, 32'h00001999, 32'h0000ECCE, 1'b0};
      vt[1] = '{32'h00030000, 32'h00010000, 32'h00020000, 32'h00010000, 32'h00010000, 32'h00008000, 32'h00028000, 1'b0};
      vt[2] = '{32'h00000000, 32'hFFFF0000, 32'h00010000, 32'h00000000, 32'h00010000, 32'h00010000, 32'h00010000, 1'b0};
      vt[3] = '{32'h00000000, 32'hFFFFFFFF, 32'h00008000, 32'h00000000, 32'h00010000, 32'h00010000, 32'h00000001, 1'b0};
      vt[4] = '{32'h7FFF0000, 32'h00000000, 32'h00000000, 32'h7FFF0000, 32'h00010000, 32'h00020000, 32'h7FFFFFFF, 1'b1};
      vt[5] = '{32'h80000000, 32'h00000000, 32'h00000000, 32'h80000000, 32'h00010000, 32'h00010000, 32'h80000000, 1'b1};
      vt[6] = '{32'h00050000, 32'h00020000, 32'h00030000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0};

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      drive(0, 0, 0, 0);
      #23 rst_n = 1'b1;
      step(1);

      // Reset state
      @(negedge clk);
      chk_i("rst_out_valid", int'(bus.out_valid), 0);
      chk_v("rst_out_y_next", bus.out_y_next, '0);
      chk_i("rst_out_idx", int'(bus.out_idx), 0);
      chk_i("rst_out_last", int'(bus.out_last), 0);
      chk_i("rst_sat_count", int'(sat_count), 0);
      chk_i("rst_in_ready", int'(bus.in_ready), 1);
      step(1);

      // Single beat, then complete the frame so the stream starts at idx 0
      send(0, 0, 0, 0, 1'b1);
      wait_drain();
      send(6, 6, 6, 6, 1'b1);
      wait_drain();

      // Back-to-back stream of four beats, mixed lanes included
      send(1, 1, 1, 1, 1'b1);
      send(2, 3, 5, 6, 1'b1);
      send(0, 0, 0, 0, 1'b1);
      send(6, 6, 6, 6, 1'b1);
      wait_drain();

      // Overflow: clear first, then one saturating beat
      clear_stats = 1'b1;
      step(1);
      clear_stats = 1'b0;
      step(1);
      send(4, 4, 4, 4, 1'b1);
      wait_drain();

      // Same beat with clear_stats landing on its output handshake
      send(4, 4, 4, 4, 1'b0);
      step(3);
      chk_i("clr_on_hs_out_valid", int'(bus.out_valid), 1);
      clear_stats = 1'b1;
      step(1);
      clear_stats = 1'b0;
      wait_drain();

      // Counter sticks at all-ones
      for (int i = 0; i < 4; i++) send(4, 4, 4, 4, 1'b1);
      wait_drain();

      // Five-cycle output stall in the middle of an eight-beat stream
      fork
         begin
            for (int b = 0; b < 8; b++)
               send(pat[b%4][0], pat[b%4][1], pat[b%4][2], pat[b%4][3], 1'b0);
         end
         begin
            step(6);
            bus.out_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               chk_i("stall_out_valid", int'(bus.out_valid), 1);
               chk_i("stall_in_ready", int'(bus.in_ready), 0);
               if (i == 0) hold = bus.out_y_next;
               else chk_v("stall_hold", bus.out_y_next, hold);
               step(1);
            end
            bus.out_ready = 1'b1;
         end
      join
      wait_drain();

      // Flush right after accepting beat idx 0; the beat offered during flush is refused
      send(1, 1, 1, 1, 1'b0);
      flush = 1'b1;
      drive(0, 0, 0, 0);
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk_i("flush_in_ready", int'(bus.in_ready), 0);
      step(1);
      flush = 1'b0;
      bus.in_valid = 1'b0;
      sb_q.delete();
      tb_idx = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk_i("flush_no_output", int'(bus.out_valid), 0);
         step(1);
      end
      send(0, 0, 0, 0, 1'b1);
      wait_drain();

      // Asynchronous reset while the output is stalled
      bus.out_ready = 1'b0;
      send(1, 1, 1, 1, 1'b0);
      send(2, 3, 5, 6, 1'b0);
      step(5);
      #2 rst_n = 1'b0;
      #1;
      chk_i("arst_out_valid", int'(bus.out_valid), 0);
      chk_i("arst_sat_count", int'(sat_count), 0);
      chk_v("arst_out_y_next", bus.out_y_next, '0);
      sb_q.delete();
      tb_idx  = 0;
      exp_sat = 0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      bus.out_ready = 1'b1;
      step(1);
      send(1, 1, 1, 1, 1'b1);
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
